// File: rtl/interleaver_ctrl_if.sv
// Handshake and shift-register control bundle for interleaver_ctrl.
// The abort signal exists only when ILV_ABORT_EN is defined.
interface interleaver_ctrl_if;
    logic        k_size_6144;
    logic        in_valid;
    logic        in_ready;
    logic        ready_in;
    logic        out_ready;
    logic        sreg_shift;
    logic        sreg_clr;
    logic        k_sel;
    logic [13:0] mux_ind;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        block_done;
`ifdef ILV_ABORT_EN
    logic        abort;

    modport master (
        output k_size_6144, in_valid, ready_in, out_ready, abort,
        input  in_ready, sreg_shift, sreg_clr, k_sel, mux_ind,
               out_valid, out_last, busy, block_done
    );

    modport slave (
        input  k_size_6144, in_valid, ready_in, out_ready, abort,
        output in_ready, sreg_shift, sreg_clr, k_sel, mux_ind,
               out_valid, out_last, busy, block_done
    );
`else
    modport master (
        output k_size_6144, in_valid, ready_in, out_ready,
        input  in_ready, sreg_shift, sreg_clr, k_sel, mux_ind,
               out_valid, out_last, busy, block_done
    );

    modport slave (
        input  k_size_6144, in_valid, ready_in, out_ready,
        output in_ready, sreg_shift, sreg_clr, k_sel, mux_ind,
               out_valid, out_last, busy, block_done
    );
`endif
endinterface

// File: rtl/interleaver_ctrl.sv
// Load/stream sequencer for a turbo-code interleaver block (K_SMALL or K_LARGE bits).
// Define ILV_ABORT_EN to add the abort input that flushes an in-flight block.
//
// state  | meaning
// IDLE   | waiting for the first byte of a block; k_size_6144 latched on accept
// LOAD   | shifting bytes into the input register until N = K/8 bytes
// FULL   | block loaded, waiting for ready_in
// STREAM | presenting bit indices 0..K-1 on mux_ind with valid/ready
// FLUSH  | one cycle: clear the shift register, then back to IDLE
module interleaver_ctrl #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144
) (
    input logic            CLOCK_50,
    input logic            KEY_0,
    interleaver_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FULL   = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    localparam logic [9:0]  N_SMALL    = 10'(K_SMALL / 8);
    localparam logic [9:0]  N_LARGE    = 10'(K_LARGE / 8);
    localparam logic [13:0] LAST_SMALL = 14'(K_SMALL - 1);
    localparam logic [13:0] LAST_LARGE = 14'(K_LARGE - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [13:0] mux_q, mux_d;
    logic        k_sel_q, k_sel_d;
    logic        done_d;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic        block_done_q;
    logic        sreg_clr_q;

    logic        accept;
    logic        abort_req;
    logic [9:0]  n_cur;
    logic [9:0]  n_new;
    logic [13:0] last_idx;

    assign accept   = bus.in_valid & in_ready_q;
    assign n_cur    = k_sel_q ? N_LARGE : N_SMALL;
    assign n_new    = bus.k_size_6144 ? N_LARGE : N_SMALL;
    assign last_idx = k_sel_q ? LAST_LARGE : LAST_SMALL;

`ifdef ILV_ABORT_EN
    // A block already in FLUSH is finishing anyway; abort only matters before that.
    assign abort_req = bus.abort && (state_q != IDLE) && (state_q != FLUSH);
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mux_d   = mux_q;
        k_sel_d = k_sel_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    k_sel_d = bus.k_size_6144;
                    cnt_d   = 10'd1;
                    state_d = (n_new == 10'd1) ? FULL : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q + 10'd1 == n_cur) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.ready_in) begin
                    state_d = STREAM;
                    mux_d   = 14'd0;
                end
            end
            STREAM: begin
                if (out_valid_q && bus.out_ready) begin
                    if (mux_q == last_idx) begin
                        state_d = FLUSH;
                        mux_d   = 14'd0;
                        done_d  = 1'b1;
                    end else begin
                        mux_d = mux_q + 14'd1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                cnt_d   = 10'd0;
                mux_d   = 14'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 10'd0;
                mux_d   = 14'd0;
            end
        endcase
        if (abort_req) begin
            state_d = FLUSH;
            cnt_d   = 10'd0;
            mux_d   = 14'd0;
            done_d  = 1'b0;
        end
    end

    // Outputs are registered from the next state so they are glitch-free and
    // drop to zero directly under the asynchronous reset.
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            state_q      <= IDLE;
            cnt_q        <= 10'd0;
            mux_q        <= 14'd0;
            k_sel_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            block_done_q <= 1'b0;
            sreg_clr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mux_q        <= mux_d;
            k_sel_q      <= k_sel_d;
            in_ready_q   <= (state_d == IDLE) || (state_d == LOAD);
            out_valid_q  <= (state_d == STREAM);
            out_last_q   <= (state_d == STREAM) && (mux_d == last_idx);
            busy_q       <= (state_d != IDLE);
            block_done_q <= done_d;
            sreg_clr_q   <= (state_d == FLUSH);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.sreg_shift = accept;
    assign bus.sreg_clr   = sreg_clr_q;
    assign bus.k_sel      = k_sel_q;
    assign bus.mux_ind    = mux_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = busy_q;
    assign bus.block_done = block_done_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Randomized self-checking bench for interleaver_ctrl against a block-level model
// (bytes accepted per block, expected bit index per handshake).
module tb_interleaver_ctrl;

    localparam int KS = 1056;
    localparam int KL = 6144;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #10 clk = ~clk;

    interleaver_ctrl_if bus ();

    interleaver_ctrl #(.K_SMALL(KS), .K_LARGE(KL)) dut (
        .CLOCK_50 (clk),
        .KEY_0    (rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.in_valid  = 1'b0;
        bus.ready_in  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef ILV_ABORT_EN
        bus.abort     = 1'b0;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},   bus.in_ready,   0);
        chk({tag, "_sreg_shift"}, bus.sreg_shift, 0);
        chk({tag, "_sreg_clr"},   bus.sreg_clr,   0);
        chk({tag, "_k_sel"},      bus.k_sel,      0);
        chk({tag, "_mux_ind"},    bus.mux_ind,    0);
        chk({tag, "_out_valid"},  bus.out_valid,  0);
        chk({tag, "_out_last"},   bus.out_last,   0);
        chk({tag, "_busy"},       bus.busy,       0);
        chk({tag, "_block_done"}, bus.block_done, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},   bus.in_ready,   1);
        chk({tag, "_busy"},       bus.busy,       0);
        chk({tag, "_sreg_clr"},   bus.sreg_clr,   0);
        chk({tag, "_block_done"}, bus.block_done, 0);
        chk({tag, "_out_valid"},  bus.out_valid,  0);
        chk({tag, "_mux_ind"},    bus.mux_ind,    0);
    endtask

    // Model: N = K/8 bytes, each cycle with in_valid while fewer than N are held is an accept.
    task automatic load_block(input bit k, input int gap_pct, input bit toggle_k,
                              input bit rand_ready_in);
        int n;
        int acc;
        int cyc;
        n   = k ? KL / 8 : KS / 8;
        acc = 0;
        cyc = 0;
        bus.k_size_6144 = k;
        while (acc < n && cyc < 20000) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            if (toggle_k && acc > 0) bus.k_size_6144 = 1'($urandom_range(1));
            bus.ready_in = rand_ready_in ? 1'($urandom_range(1)) : 1'b0;
            #1;
            chk("load_in_ready",   bus.in_ready,   1);
            chk("load_sreg_shift", bus.sreg_shift, bus.in_valid);
            chk("load_busy",       bus.busy,       (acc > 0));
            chk("load_sreg_clr",   bus.sreg_clr,   0);
            chk("load_out_valid",  bus.out_valid,  0);
            if (acc > 0) chk("load_k_sel_hold", bus.k_sel, k);
            if (bus.in_valid) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("load_timeout", (cyc < 20000), 1);
        if (gap_pct == 0) chk("load_cycles", cyc, n);
        bus.ready_in = 1'b0;
        // Block is full: further bytes must be refused and the block held.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.k_size_6144 = ~k;
            #1;
            chk("full_in_ready",   bus.in_ready,   0);
            chk("full_sreg_shift", bus.sreg_shift, 0);
            chk("full_busy",       bus.busy,       1);
            chk("full_k_sel",      bus.k_sel,      k);
            chk("full_out_valid",  bus.out_valid,  0);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Model: expected index starts at 0 and advances on each accepted bit until K-1.
    task automatic stream_block(input int k_len, input int rdy_pct, input int stall_at,
                                input int reset_at);
        int idx;
        int cyc;
        int stalls;
        bit done;
        idx    = 0;
        cyc    = 0;
        stalls = 0;
        done   = 1'b0;
        bus.ready_in = 1'b1;
        #1;
        chk("start_out_valid_late", bus.out_valid, 0);
        tick();
        bus.ready_in = 1'b0;
        while (!done && cyc < 40000) begin
            if (reset_at >= 0 && idx == reset_at) begin
                chk("pre_reset_mux_ind", bus.mux_ind, reset_at);
                bus.in_valid  = 1'b1;
                bus.out_ready = 1'b1;
                #3;
                rst_n = 1'b0;
                #1;
                chk_all_zero("async_rst");
                @(negedge clk);
                chk_all_zero("held_rst");
                quiet_inputs();
                rst_n = 1'b1;
                tick();
                chk_idle("post_rst");
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("post_rst_no_done", bus.block_done, 0);
                    chk("post_rst_no_clr",  bus.sreg_clr,   0);
                end
                return;
            end
            if (idx == stall_at && stalls < 5) begin
                bus.out_ready = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = ($urandom_range(99) < rdy_pct);
            end
            #1;
            chk("str_out_valid", bus.out_valid, 1);
            chk("str_mux_ind",   bus.mux_ind,   idx);
            chk("str_out_last",  bus.out_last,  (idx == k_len - 1));
            chk("str_busy",      bus.busy,      1);
            chk("str_in_ready",  bus.in_ready,  0);
            chk("str_sreg_clr",  bus.sreg_clr,  0);
            chk("str_done",      bus.block_done, 0);
            if (bus.out_ready) begin
                if (idx == k_len - 1) done = 1'b1;
                else idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stream_timeout", (cyc < 40000), 1);
        if (stall_at >= 0) chk("stall_cycles", stalls, 5);
        bus.out_ready = 1'b0;
        #1;
        chk("flush_sreg_clr",   bus.sreg_clr,   1);
        chk("flush_block_done", bus.block_done, 1);
        chk("flush_busy",       bus.busy,       1);
        chk("flush_out_valid",  bus.out_valid,  0);
        chk("flush_out_last",   bus.out_last,   0);
        chk("flush_in_ready",   bus.in_ready,   0);
        tick();
        chk_idle("after_flush");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet_inputs();
        bus.k_size_6144 = 1'b0;
        rst_n = 1'b0;
        #5;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("reset_release");
        chk("reset_k_sel", bus.k_sel, 0);

        // ready_in while idle must not be remembered
        bus.ready_in = 1'b1;
        tick();
        tick();
        bus.ready_in = 1'b0;
        chk_idle("idle_ready_in");

        load_block(1'b0, 0, 1'b0, 1'b0);
        stream_block(KS, 100, -1, -1);

        load_block(1'b1, 30, 1'b1, 1'b1);
        stream_block(KL, 70, 10, -1);

        load_block(1'b0, 50, 1'b0, 1'b1);
        stream_block(KS, 80, -1, 500);

`ifdef ILV_ABORT_EN
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_idle("abort_in_idle");
        bus.k_size_6144 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_sreg_clr",   bus.sreg_clr,   1);
        chk("abort_block_done", bus.block_done, 0);
        chk("abort_busy",       bus.busy,       1);
        chk("abort_in_ready",   bus.in_ready,   0);
        tick();
        chk_idle("after_abort");
`endif

        for (int b = 0; b < 3; b++) begin
            bit k;
            k = 1'($urandom_range(1));
            load_block(k, $urandom_range(60), 1'b1, 1'b1);
            stream_block(k ? KL : KS, 40 + $urandom_range(60), $urandom_range(20), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interleaver_ctrl.md
INTERLEAVER_CTRL -- requirements
Module: interleaver_ctrl

Interface
REQ-001 SHALL have parameter K_SMALL, default 1056, meaning small block size in bits.
REQ-002 SHALL have parameter K_LARGE, default 6144, meaning large block size in bits.
REQ-003 SHALL have port CLOCK_50  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port KEY_0  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port k_size_6144  in  1  block size select: 0 = K_SMALL, 1 = K_LARGE.
REQ-006 SHALL have port in_valid  in  1  upstream byte present on the shift-register data input.
REQ-007 SHALL have port in_ready  out  1  controller accepts a byte this cycle.
REQ-008 SHALL have port ready_in  in  1  request to start serial output of a loaded block.
REQ-009 SHALL have port out_ready  in  1  downstream consumes the current output bit.
REQ-010 SHALL have port sreg_shift  out  1  shift enable to the 6144-bit input shift register.
REQ-011 SHALL have port sreg_clr  out  1  one-cycle clear pulse to the shift register.
REQ-012 SHALL have port k_sel  out  1  latched block size, driving interleaver K_eq_6144.
REQ-013 SHALL have port mux_ind  out  14  bit index driving both output muxes (outi, outpii).
REQ-014 SHALL have ports out_valid, out_last, busy, block_done  out  1 each: bit valid, final bit, block in flight, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD, FULL, STREAM, FLUSH.
REQ-016 SHALL set N = K/8 bytes (132 or 768); byte counter 10 bits; mux_ind counts 0..K-1.
REQ-017 SHALL drive in_ready = 1 only in IDLE and LOAD; sreg_shift = in_valid & in_ready, combinational, same cycle.
REQ-018 SHALL, on the first accepted byte in IDLE, latch k_size_6144 into k_sel, set the byte count to 1, and go to LOAD (or FULL when N = 1).
REQ-019 SHALL ignore k_size_6144 changes after latching until the next IDLE acceptance.
REQ-020 SHALL, in LOAD, increment the byte count per accepted byte; the accept that makes count = N goes to FULL, with in_ready = 0 from the next cycle.
REQ-021 SHALL, in FULL, hold until ready_in is sampled 1, then enter STREAM with mux_ind = 0; out_valid rises the cycle after ready_in is sampled.
REQ-022 SHALL ignore ready_in in IDLE and LOAD and not remember it.
REQ-023 SHALL, in STREAM, hold out_valid = 1 and mux_ind stable while out_ready = 0; each out_valid & out_ready cycle advances mux_ind by 1.
REQ-024 SHALL assert out_last = 1 exactly when in STREAM with mux_ind = K-1.
REQ-025 SHALL, on the handshake at mux_ind = K-1, go to FLUSH and never advance mux_ind past K-1.
REQ-026 SHALL, in FLUSH (exactly one cycle), assert sreg_clr = 1 and block_done = 1, reset mux_ind to 0, then return to IDLE.
REQ-027 SHALL assert busy = 1 in every state except IDLE.
REQ-028 SHALL never assert sreg_shift and sreg_clr in the same cycle.

Reset
REQ-029 SHALL, while KEY_0 = 0, force state IDLE, byte count 0, mux_ind 0, k_sel 0, and all outputs 0, except in_ready = 0 during reset and 1 in IDLE after release.
REQ-030 SHALL treat reset mid-LOAD or mid-STREAM as abandoning the block; no block_done pulse; shift-register contents are not cleared by this block.

Configuration
REQ-031 SHALL, with ILV_ABORT_EN defined, add input abort (1 bit): abort = 1 in any non-IDLE state forces FLUSH next cycle (sreg_clr pulse, block_done = 0, then IDLE); abort in IDLE has no effect.
REQ-032 SHALL, without ILV_ABORT_EN, have no abort port and no abort logic.

Verification
REQ-033 SHALL verify: k=0, 132 consecutive in_valid bytes -> sreg_shift high 132 cycles, then FULL, in_ready = 0, busy = 1.
REQ-034 SHALL verify: loaded K=1056, ready_in pulse, out_ready held 1 -> mux_ind 0..1055 on consecutive cycles, out_last only at 1055, then one sreg_clr + block_done cycle, then IDLE.
REQ-035 SHALL verify: k=1, 768 bytes with in_valid gaps, k_size_6144 toggled mid-load -> k_sel stays 1, FULL after the 768th byte.
REQ-036 SHALL verify: STREAM with out_ready = 0 for 5 cycles at mux_ind = 10 -> mux_ind holds 10 and out_valid stays 1; resumes at 11.
REQ-037 SHALL verify: KEY_0 low at mux_ind = 500 -> all outputs 0 asynchronously; after release IDLE, in_ready = 1, no block_done.
REQ-038 SHALL verify, with ILV_ABORT_EN: abort at byte 40 of LOAD -> next cycle sreg_clr = 1, block_done = 0, then IDLE.
